a2bus_event_capture: RTL and testbench

A2BUS_EVENT_CAPTURE -- requirements
Module: a2bus_event_capture

---
 rtl/a2bus_capture_pkg.sv | 21 ++
 rtl/a2bus_if.sv | 12 +
 rtl/a2bus_event_fifo.sv | 61 ++++++
 rtl/a2bus_event_capture.sv | 154 +++++++++++++++
 tb/tb_a2bus_event_capture.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/a2bus_capture_pkg.sv
// Shared types and constants for the A2 bus event capture block.
package a2bus_capture_pkg;

  // One captured bus cycle as stored in the FIFO.
  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        rw_n;
  } a2bus_event_t;

  // Occupancy-tracking control states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FULL   = 2'd2
  } cap_state_t;

  // The drop counter saturates here instead of wrapping.
  localparam logic [7:0] DROP_COUNT_MAX = 8'hFF;

endpackage

// File: rtl/a2bus_if.sv
// A2 bus snoop signals; the bus model drives them, the capture block listens.
interface a2bus_if;

  logic [15:0] addr;
  logic [7:0]  data;
  logic        rw_n;
  logic        data_in_strobe;

  modport master (output addr, data, rw_n, data_in_strobe);
  modport slave  (input  addr, data, rw_n, data_in_strobe);

endinterface

// File: rtl/a2bus_event_fifo.sv
// First-word-fall-through event FIFO: storage, wrapping pointers and occupancy.
// The caller never pushes into a full FIFO without a pop, nor pops when empty.
module a2bus_event_fifo
  import a2bus_capture_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  a2bus_event_t           wr_data,
  output a2bus_event_t           rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  a2bus_event_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Storage write; the RAM holds no reset so it can map to plain memory.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointer and occupancy update; flush wins over any push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == CW'(DEPTH));

endmodule

// File: rtl/a2bus_event_capture.sv
// A2 bus event capture: snoops bus cycles inside [ADDR_LO, ADDR_HI], queues
// them in a FIFO for a ready/valid consumer and tracks dropped events.
// Build option: define A2BUS_CAPTURE_READS_EN to capture read cycles too;
// without it only writes are captured and ev_rw_n_o is tied to 0.
module a2bus_event_capture
  import a2bus_capture_pkg::*;
#(
  parameter int          DEPTH   = 16,
  parameter logic [15:0] ADDR_LO = 16'hC000,
  parameter logic [15:0] ADDR_HI = 16'hC0FF
) (
  input  logic                   clk_logic,
  input  logic                   device_reset_n,
  a2bus_if.slave                 bus,
  input  logic                   flush_i,
  input  logic                   ev_ready_i,
  output logic                   ev_valid_o,
  output logic [15:0]            ev_addr_o,
  output logic [7:0]             ev_data_o,
  output logic                   ev_rw_n_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   overflow_o,
  input  logic                   overflow_clr_i,
  output logic [7:0]             drop_count_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [15:0]  addr_i;
  logic [7:0]   data_i;
  logic         rw_n_i;
  logic         data_in_strobe_i;
  logic         dir_ok;
  logic         match;
  logic         s1_valid;
  a2bus_event_t s1_event;
  a2bus_event_t head;
  logic         fifo_full;
  logic         pop;
  logic         push_accept;
  logic         drop;
  cap_state_t   state;
  cap_state_t   state_next;

  assign addr_i           = bus.addr;
  assign data_i           = bus.data;
  assign rw_n_i           = bus.rw_n;
  assign data_in_strobe_i = bus.data_in_strobe;

`ifdef A2BUS_CAPTURE_READS_EN
  assign dir_ok = 1'b1;
`else
  assign dir_ok = ~rw_n_i;
`endif

  assign match = data_in_strobe_i && (addr_i >= ADDR_LO) && (addr_i <= ADDR_HI) && dir_ok;

  // Stage 1: register the match decision together with the bus fields.
  always_ff @(posedge clk_logic or negedge device_reset_n) begin
    if (!device_reset_n) begin
      s1_valid <= 1'b0;
      s1_event <= '0;
    end else begin
      s1_valid <= match && !flush_i;
      if (data_in_strobe_i) begin
        s1_event <= '{addr: addr_i, data: data_i, rw_n: rw_n_i};
      end
    end
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pop         = ev_valid_o && ev_ready_i;
  assign push_accept = s1_valid && (!fifo_full || pop);
  assign drop        = s1_valid && fifo_full && !pop && !flush_i;

  a2bus_event_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk_logic),
    .rst_n   (device_reset_n),
    .flush   (flush_i),
    .push    (push_accept),
    .pop     (pop),
    .wr_data (s1_event),
    .rd_data (head),
    .count   (count_o),
    .full    (fifo_full)
  );

  // Control FSM state register.
  always_ff @(posedge clk_logic or negedge device_reset_n) begin
    if (!device_reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Control FSM transitions, following occupancy changes one step ahead.
  always_comb begin
    state_next = state;
    if (flush_i) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (push_accept) state_next = ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (push_accept && !pop && (count_o == CW'(DEPTH - 1))) begin
            state_next = ST_FULL;
          end else if (pop && !push_accept && (count_o == CW'(1))) begin
            state_next = ST_IDLE;
          end
        end
        ST_FULL: begin
          if (pop && !push_accept) state_next = ST_ACTIVE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign ev_valid_o = (state != ST_IDLE);
  assign ev_addr_o  = ev_valid_o ? head.addr : 16'h0000;
  assign ev_data_o  = ev_valid_o ? head.data : 8'h00;

`ifdef A2BUS_CAPTURE_READS_EN
  assign ev_rw_n_o = ev_valid_o ? head.rw_n : 1'b1;
`else
  // Only writes are ever queued, so the direction bit is known to be 0.
  logic unused_head_rw_n;
  assign unused_head_rw_n = head.rw_n;
  assign ev_rw_n_o        = 1'b0;
`endif

  // Sticky overflow and saturating drop counter; a clear that coincides with
  // a drop restarts the tally at that drop.
  always_ff @(posedge clk_logic or negedge device_reset_n) begin
    if (!device_reset_n) begin
      overflow_o   <= 1'b0;
      drop_count_o <= 8'h00;
    end else if (overflow_clr_i) begin
      overflow_o   <= drop;
      drop_count_o <= drop ? 8'h01 : 8'h00;
    end else if (drop) begin
      overflow_o <= 1'b1;
      if (drop_count_o != DROP_COUNT_MAX) begin
        drop_count_o <= drop_count_o + 8'h01;
      end
    end
  end

endmodule

// File: tb/tb_a2bus_event_capture.sv
// Self-checking bench for a2bus_event_capture: a directed vector table, hand
// sequences for fill/overflow/flush/reset, then random traffic against a
// queue-based reference model. Honours A2BUS_CAPTURE_READS_EN when defined.
module tb_a2bus_event_capture;
  import a2bus_capture_pkg::*;

  localparam int          DEPTH   = 16;
  localparam logic [15:0] ADDR_LO = 16'hC000;
  localparam logic [15:0] ADDR_HI = 16'hC0FF;
`ifdef A2BUS_CAPTURE_READS_EN
  localparam logic READS_EN = 1'b1;
`else
  localparam logic READS_EN = 1'b0;
`endif

  logic        clk_logic      = 1'b0;
  logic        device_reset_n = 1'b0;
  logic        flush_i        = 1'b0;
  logic        ev_ready_i     = 1'b0;
  logic        overflow_clr_i = 1'b0;
  logic        ev_valid_o;
  logic [15:0] ev_addr_o;
  logic [7:0]  ev_data_o;
  logic        ev_rw_n_o;
  logic [4:0]  count_o;
  logic        overflow_o;
  logic [7:0]  drop_count_o;

  a2bus_if bus_if ();

  a2bus_event_capture #(
    .DEPTH   (DEPTH),
    .ADDR_LO (ADDR_LO),
    .ADDR_HI (ADDR_HI)
  ) dut (
    .clk_logic      (clk_logic),
    .device_reset_n (device_reset_n),
    .bus            (bus_if.slave),
    .flush_i        (flush_i),
    .ev_ready_i     (ev_ready_i),
    .ev_valid_o     (ev_valid_o),
    .ev_addr_o      (ev_addr_o),
    .ev_data_o      (ev_data_o),
    .ev_rw_n_o      (ev_rw_n_o),
    .count_o        (count_o),
    .overflow_o     (overflow_o),
    .overflow_clr_i (overflow_clr_i),
    .drop_count_o   (drop_count_o)
  );

  always #5 clk_logic = ~clk_logic;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: events waiting one cycle after the strobe, then a queue.
  a2bus_event_t model_q[$];
  logic         pend_valid = 1'b0;
  a2bus_event_t pend_ev    = '0;
  logic         m_ovf      = 1'b0;
  int           m_drop     = 0;

  typedef struct {
    logic        strobe;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        rw_n;
    logic        ready;
    logic        flush;
    logic        clr;
    logic        exp_valid;
    logic [15:0] exp_addr;
    logic [7:0]  exp_data;
    logic        exp_rw;
    int          exp_count;
  } vec_t;

  vec_t table_v[12];

  // Advance the reference model by one rising edge using the current inputs.
  task automatic modelEdge();
    logic do_pop;
    logic do_drop;
    logic hit;
    do_pop  = (model_q.size() > 0) && ev_ready_i;
    do_drop = 1'b0;
    hit = bus_if.data_in_strobe && (bus_if.addr >= ADDR_LO) && (bus_if.addr <= ADDR_HI)
          && (READS_EN || !bus_if.rw_n);
    if (flush_i) begin
      model_q.delete();
      pend_valid = 1'b0;
    end else begin
      if (do_pop) void'(model_q.pop_front());
      if (pend_valid) begin
        if (model_q.size() < DEPTH) model_q.push_back(pend_ev);
        else do_drop = 1'b1;
      end
      pend_valid = hit;
      pend_ev    = '{addr: bus_if.addr, data: bus_if.data, rw_n: bus_if.rw_n};
    end
    if (overflow_clr_i) begin
      m_ovf  = do_drop;
      m_drop = do_drop ? 1 : 0;
    end else if (do_drop) begin
      m_ovf = 1'b1;
      if (m_drop < 255) m_drop++;
    end
  endtask

  task automatic modelReset();
    model_q.delete();
    pend_valid = 1'b0;
    m_ovf      = 1'b0;
    m_drop     = 0;
  endtask

  // Drive one cycle of inputs, take the rising edge, settle just after it.
  task automatic applyStimulus(input logic strobe, input logic [15:0] addr, input logic [7:0] data,
                               input logic rw_n, input logic ready, input logic flush,
                               input logic clr);
    bus_if.data_in_strobe = strobe;
    bus_if.addr           = addr;
    bus_if.data           = data;
    bus_if.rw_n           = rw_n;
    ev_ready_i            = ready;
    flush_i               = flush;
    overflow_clr_i        = clr;
    @(posedge clk_logic);
    modelEdge();
    #1;
  endtask

  task automatic idleCycle(input logic ready, input logic flush, input logic clr);
    applyStimulus(1'b0, 16'h0000, 8'h00, 1'b0, ready, flush, clr);
  endtask

  // Compare every output against the reference model.
  task automatic checkOutput(input string name);
    logic        e_valid;
    logic [15:0] e_addr;
    logic [7:0]  e_data;
    logic        e_rw;
    e_valid = model_q.size() > 0;
    e_addr  = e_valid ? model_q[0].addr : 16'h0000;
    e_data  = e_valid ? model_q[0].data : 8'h00;
    e_rw    = READS_EN ? (e_valid ? model_q[0].rw_n : 1'b1) : 1'b0;
    vectors++;
    if (ev_valid_o !== e_valid || ev_addr_o !== e_addr || ev_data_o !== e_data ||
        ev_rw_n_o !== e_rw || count_o !== 5'(model_q.size()) || overflow_o !== m_ovf ||
        drop_count_o !== 8'(m_drop)) begin
      miscompares++;
      $display("[TB] FAIL %s: got v=%0b a=%h d=%h rw=%0b cnt=%0d ovf=%0b drop=%0d, expected v=%0b a=%h d=%h rw=%0b cnt=%0d ovf=%0b drop=%0d",
               name, ev_valid_o, ev_addr_o, ev_data_o, ev_rw_n_o, count_o, overflow_o,
               drop_count_o, e_valid, e_addr, e_data, e_rw, model_q.size(), m_ovf, m_drop);
    end
  endtask

  task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkResetValues(input string name);
    checkValue({name, " valid"}, 32'(ev_valid_o), 32'h0);
    checkValue({name, " addr"}, 32'(ev_addr_o), 32'h0);
    checkValue({name, " data"}, 32'(ev_data_o), 32'h0);
    checkValue({name, " rw_n"}, 32'(ev_rw_n_o), 32'(READS_EN));
    checkValue({name, " count"}, 32'(count_o), 32'h0);
    checkValue({name, " ovf"}, 32'(overflow_o), 32'h0);
    checkValue({name, " drop"}, 32'(drop_count_o), 32'h0);
  endtask

  initial begin
    logic [15:0] r_addr;
    bus_if.data_in_strobe = 1'b0;
    bus_if.addr           = 16'h0000;
    bus_if.data           = 8'h00;
    bus_if.rw_n           = 1'b0;

    // Directed table: each row is one cycle of inputs and the outputs after its edge.
    table_v[0]  = '{1'b1, 16'hC030, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, READS_EN, 0};
    table_v[1]  = '{1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hC030, 8'h5A, 1'b0, 1};
    table_v[2]  = '{1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, READS_EN, 0};
    table_v[3]  = '{1'b1, 16'hBFFF, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, READS_EN, 0};
    table_v[4]  = '{1'b1, 16'hC100, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, READS_EN, 0};
    table_v[5]  = '{1'b1, 16'hC0FF, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, READS_EN, 0};
    table_v[6]  = '{1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hC0FF, 8'h11, 1'b0, 1};
    table_v[7]  = '{1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hC0FF, 8'h11, 1'b0, 1};
    table_v[8]  = '{1'b1, 16'hC0E0, 8'h44, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'hC0FF, 8'h11, 1'b0, 1};
`ifdef A2BUS_CAPTURE_READS_EN
    table_v[9]  = '{1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hC0FF, 8'h11, 1'b0, 2};
    table_v[10] = '{1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'hC0E0, 8'h44, 1'b1, 1};
`else
    table_v[9]  = '{1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hC0FF, 8'h11, 1'b0, 1};
    table_v[10] = '{1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 0};
`endif
    table_v[11] = '{1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, READS_EN, 0};

    // Reset values with no clock edge seen yet, then after a few edges in reset.
    #2;
    checkResetValues("reset_noedge");
    repeat (2) @(posedge clk_logic);
    #1;
    checkResetValues("reset_held");
    device_reset_n = 1'b1;
    modelReset();

    foreach (table_v[i]) begin
      applyStimulus(table_v[i].strobe, table_v[i].addr, table_v[i].data, table_v[i].rw_n,
                    table_v[i].ready, table_v[i].flush, table_v[i].clr);
      vectors++;
      if (ev_valid_o !== table_v[i].exp_valid || ev_addr_o !== table_v[i].exp_addr ||
          ev_data_o !== table_v[i].exp_data || ev_rw_n_o !== table_v[i].exp_rw ||
          count_o !== 5'(table_v[i].exp_count)) begin
        miscompares++;
        $display("[TB] FAIL table[%0d]: got v=%0b a=%h d=%h rw=%0b cnt=%0d, expected v=%0b a=%h d=%h rw=%0b cnt=%0d",
                 i, ev_valid_o, ev_addr_o, ev_data_o, ev_rw_n_o, count_o, table_v[i].exp_valid,
                 table_v[i].exp_addr, table_v[i].exp_data, table_v[i].exp_rw, table_v[i].exp_count);
      end
      checkOutput($sformatf("table_model[%0d]", i));
    end

    // Fill to capacity with the consumer stalled, then overrun by three.
    for (int i = 0; i < DEPTH + 3; i++) begin
      applyStimulus(1'b1, ADDR_LO + 16'(i), 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("fill");
    end
    idleCycle(1'b0, 1'b0, 1'b0);
    idleCycle(1'b0, 1'b0, 1'b0);
    checkOutput("fill_settled");
    checkValue("full_count", 32'(count_o), 32'd16);
    checkValue("full_ovf", 32'(overflow_o), 32'd1);
    checkValue("full_drop", 32'(drop_count_o), 32'd3);
    checkValue("full_head", 32'(ev_addr_o), 32'hC000);

    // Push and pop in the same cycle while full: no drop, head advances.
    applyStimulus(1'b1, 16'hC0AA, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0);
    idleCycle(1'b1, 1'b0, 1'b0);
    checkOutput("full_pushpop");
    checkValue("pushpop_count", 32'(count_o), 32'd16);
    checkValue("pushpop_drop", 32'(drop_count_o), 32'd3);
    checkValue("pushpop_head", 32'(ev_addr_o), 32'hC001);

    // Clearing alone zeroes the flags; a clear that meets a drop counts it.
    idleCycle(1'b0, 1'b0, 1'b1);
    checkValue("clr_ovf", 32'(overflow_o), 32'd0);
    checkValue("clr_drop", 32'(drop_count_o), 32'd0);
    applyStimulus(1'b1, 16'hC0BB, 8'hBB, 1'b0, 1'b0, 1'b0, 1'b0);
    idleCycle(1'b0, 1'b0, 1'b1);
    checkOutput("clr_with_drop");
    checkValue("clrdrop_ovf", 32'(overflow_o), 32'd1);
    checkValue("clrdrop_drop", 32'(drop_count_o), 32'd1);

    // Flush to empty, refill to five and flush against a pending push.
    idleCycle(1'b0, 1'b1, 1'b0);
    checkOutput("flush_full");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 16'hC050 + 16'(i), 8'h60 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    checkValue("pre_flush_count", 32'(count_o), 32'd5);
    idleCycle(1'b0, 1'b1, 1'b0);
    checkOutput("flush_push");
    checkValue("flush_count", 32'(count_o), 32'd0);
    checkValue("flush_valid", 32'(ev_valid_o), 32'd0);
    checkValue("flush_ovf", 32'(overflow_o), 32'd1);
    idleCycle(1'b0, 1'b0, 1'b0);
    checkValue("flush_s1_cleared", 32'(count_o), 32'd0);

    // Reset asserted between edges must clear everything immediately.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 16'hC070 + 16'(i), 8'h70 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    checkOutput("pre_reset");
    #2;
    device_reset_n = 1'b0;
    #1;
    checkResetValues("reset_midcycle");
    modelReset();
    @(posedge clk_logic);
    #1;
    checkResetValues("reset_midcycle_held");
    idleCycle(1'b0, 1'b0, 1'b0);
    device_reset_n = 1'b1;
    modelReset();

    // Random traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 9))
        0:       r_addr = ADDR_LO - 16'd1;
        1:       r_addr = ADDR_HI + 16'd1;
        2:       r_addr = ADDR_LO;
        3:       r_addr = ADDR_HI;
        4:       r_addr = 16'($urandom);
        default: r_addr = ADDR_LO + 16'($urandom_range(0, 255));
      endcase
      applyStimulus(1'($urandom_range(0, 1)), r_addr, 8'($urandom),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 4),
                    ($urandom_range(0, 49) == 0), ($urandom_range(0, 49) == 0));
      checkOutput($sformatf("random[%0d]", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
